// File: rtl/core_inst_seq.sv
// core_inst_seq
//   Instruction sequencer for the systolic-array core. It generates the packed
//   per-cycle instruction word for one complete tile pass:
//   weight fetch, weight load, activation fetch, execute, and output drain to
//   psum memory.
//
//   Optional feature macro: CORE_INST_SEQ_TIMEOUT_EN
//     When defined, a stalled drain is aborted after 1023 consecutive cycles
//     with ofifo_valid low, and err is set. When undefined, err is tied low.
//
// Ports
//   clk, reset             clock, asynchronous active-high reset
//   start                  one-cycle pulse, accepted only in IDLE
//   w_base/x_base/p_base   weight/activation xmem base, pmem output base
//   nx                     number of activation vectors (0 allowed)
//   acc_en                 accumulate into pmem instead of overwriting it
//   ofifo_valid            output FIFO holds a complete row
//   inst                   registered instruction word
//                            {acc, CEN_pmem, WEN_pmem, A_pmem, CEN_xmem, WEN_xmem,
//                             A_xmem, ofifo_rd, ififo_wr, ififo_rd, l0_rd, l0_wr,
//                             execute, load}
//   busy                   high whenever the FSM is not in IDLE
//   done                   one-cycle pulse on pass completion
//   err                    sticky drain-timeout flag
//
// state  | meaning
// IDLE   | wait for start, outputs the idle word
// WFETCH | col xmem weight reads; l0_wr trails each read by one cycle
// WLOAD  | col load cycles, then row settle cycles
// XFETCH | nx xmem activation reads; l0_wr trails each read by one cycle
// EXEC   | nx execute cycles
// DRAIN  | one pmem write per ofifo_valid cycle until nx writes are done
// DONE   | done pulse, then back to IDLE
module core_inst_seq #(
  parameter int row     = 8,
  parameter int col     = 8,
  parameter int addr_bw = 11,
  parameter int len_bw  = 8,
  parameter int INST_W  = 12 + 2*addr_bw
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [addr_bw-1:0] w_base,
  input  logic [addr_bw-1:0] x_base,
  input  logic [addr_bw-1:0] p_base,
  input  logic [len_bw-1:0]  nx,
  input  logic               acc_en,
  input  logic               ofifo_valid,
  output logic [INST_W-1:0]  inst,
  output logic               busy,
  output logic               done,
  output logic               err
);

  localparam int WL_LEN = col + row;
  localparam int CW = (($clog2(WL_LEN + 1) > len_bw) ? $clog2(WL_LEN + 1) : len_bw) + 1;
  localparam logic [CW-1:0] COL_C  = CW'(col);
  localparam logic [CW-1:0] WL_END = CW'(WL_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WFETCH, S_WLOAD, S_XFETCH, S_EXEC, S_DRAIN, S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [addr_bw-1:0]  w_q, w_d, x_q, x_d, p_q, p_d;
  logic [len_bw-1:0]   nx_q, nx_d;
  logic                acc_q, acc_d;
  logic [INST_W-1:0]   inst_q, inst_d;
  logic                busy_q, busy_d, done_q, done_d;
  logic                wr_d;
  logic [CW-1:0]       nx_ext;

  // instruction fields of the next word
  logic               f_acc, f_cen_p, f_wen_p, f_cen_x, f_wen_x;
  logic [addr_bw-1:0] f_a_p, f_a_x;
  logic               f_ofifo_rd, f_l0_rd, f_l0_wr, f_exe, f_load;

`ifdef CORE_INST_SEQ_TIMEOUT_EN
  logic [15:0] to_q, to_d;
  logic        err_q, err_d;
`endif

  assign nx_ext = CW'(nx_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    w_d     = w_q;
    x_d     = x_q;
    p_d     = p_q;
    nx_d    = nx_q;
    acc_d   = acc_q;
    done_d  = 1'b0;
    wr_d    = 1'b0;
`ifdef CORE_INST_SEQ_TIMEOUT_EN
    to_d    = to_q;
    err_d   = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_WFETCH;
          cnt_d   = '0;
          w_d     = w_base;
          x_d     = x_base;
          p_d     = p_base;
          nx_d    = nx;
          acc_d   = acc_en;
        end
      end
      S_WFETCH: begin
        if (cnt_q == COL_C) begin
          state_d = S_WLOAD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WLOAD: begin
        if (cnt_q == WL_END) begin
          cnt_d = '0;
          if (nx_q == '0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_XFETCH;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_XFETCH: begin
        if (cnt_q == nx_ext) begin
          state_d = S_EXEC;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_EXEC: begin
        if (cnt_q == nx_ext - 1'b1) begin
          state_d = S_DRAIN;
          cnt_d   = '0;
`ifdef CORE_INST_SEQ_TIMEOUT_EN
          to_d    = '0;
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DRAIN: begin
        // cnt counts completed writes; DONE follows the cycle after the last one
        if (cnt_q == nx_ext) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else if (ofifo_valid) begin
          wr_d  = 1'b1;
          cnt_d = cnt_q + 1'b1;
`ifdef CORE_INST_SEQ_TIMEOUT_EN
          to_d  = '0;
`endif
        end else begin
`ifdef CORE_INST_SEQ_TIMEOUT_EN
          // this is the 1023rd consecutive invalid cycle
          if (to_q == 16'd1022) begin
            err_d   = 1'b1;
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            to_d = to_q + 16'd1;
          end
`endif
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Decode the word for the cycle being entered, so inst lines up with state.
    f_acc      = 1'b0;
    f_cen_p    = 1'b1;
    f_wen_p    = 1'b1;
    f_a_p      = '0;
    f_cen_x    = 1'b1;
    f_wen_x    = 1'b1;
    f_a_x      = '0;
    f_ofifo_rd = 1'b0;
    f_l0_rd    = 1'b0;
    f_l0_wr    = 1'b0;
    f_exe      = 1'b0;
    f_load     = 1'b0;
    case (state_d)
      S_WFETCH: begin
        if (cnt_d < COL_C) begin
          f_cen_x = 1'b0;
          f_a_x   = w_d + addr_bw'(cnt_d);
        end
        f_l0_wr = (cnt_d != '0);
      end
      S_WLOAD: begin
        if (cnt_d < COL_C) begin
          f_l0_rd = 1'b1;
          f_load  = 1'b1;
        end
      end
      S_XFETCH: begin
        if (cnt_d < CW'(nx_d)) begin
          f_cen_x = 1'b0;
          f_a_x   = x_d + addr_bw'(cnt_d);
        end
        f_l0_wr = (cnt_d != '0);
      end
      S_EXEC: begin
        f_l0_rd = 1'b1;
        f_exe   = 1'b1;
      end
      S_DRAIN: begin
        if (wr_d) begin
          f_ofifo_rd = 1'b1;
          f_cen_p    = 1'b0;
          f_wen_p    = 1'b0;
          f_a_p      = p_q + addr_bw'(cnt_q);
          f_acc      = acc_q;
        end
      end
      default: ;
    endcase

    inst_d = {f_acc, f_cen_p, f_wen_p, f_a_p, f_cen_x, f_wen_x, f_a_x,
              f_ofifo_rd, 1'b0, 1'b0, f_l0_rd, f_l0_wr, f_exe, f_load};
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      w_q     <= '0;
      x_q     <= '0;
      p_q     <= '0;
      nx_q    <= '0;
      acc_q   <= 1'b0;
      inst_q  <= {1'b0, 1'b1, 1'b1, {addr_bw{1'b0}}, 1'b1, 1'b1, {addr_bw{1'b0}}, 7'b0};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      w_q     <= w_d;
      x_q     <= x_d;
      p_q     <= p_d;
      nx_q    <= nx_d;
      acc_q   <= acc_d;
      inst_q  <= inst_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

`ifdef CORE_INST_SEQ_TIMEOUT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      to_q  <= '0;
      err_q <= 1'b0;
    end else begin
      to_q  <= to_d;
      err_q <= err_d;
    end
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign inst = inst_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_core_inst_seq.sv
// Testbench for core_inst_seq: drives tile passes and checks the instruction
// stream against an event-level reference built from base addresses and counts.
module tb_core_inst_seq;

  localparam int ROW = 8;
  localparam int COL = 8;
  localparam int A   = 11;
  localparam int LB  = 8;
  localparam int W   = 12 + 2*A;
  localparam int AMOD = 1 << A;

  localparam int B_LOAD = 0, B_EXE = 1, B_L0WR = 2, B_L0RD = 3;
  localparam int B_IFRD = 4, B_IFWR = 5, B_OFRD = 6, B_AX = 7;
  localparam int B_WENX = 7 + A, B_CENX = 8 + A, B_AP = 9 + A;
  localparam int B_WENP = 9 + 2*A, B_CENP = 10 + 2*A, B_ACC = 11 + 2*A;

  localparam logic [W-1:0] IDLE_W = {1'b0, 1'b1, 1'b1, {A{1'b0}}, 1'b1, 1'b1, {A{1'b0}}, 7'b0};

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [A-1:0]  w_base = '0, x_base = '0, p_base = '0;
  logic [LB-1:0] nx = '0;
  logic          acc_en = 1'b0;
  logic          ofifo_valid = 1'b0;
  logic [W-1:0]  inst;
  logic          busy, done, err;

  int checks = 0;
  int errors = 0;

  core_inst_seq #(.row(ROW), .col(COL), .addr_bw(A), .len_bw(LB)) dut (
    .clk(clk), .reset(reset), .start(start),
    .w_base(w_base), .x_base(x_base), .p_base(p_base), .nx(nx),
    .acc_en(acc_en), .ofifo_valid(ofifo_valid),
    .inst(inst), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #20ms;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (inst !== IDLE_W || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: inst=%h busy=%b done=%b err=%b, required inst=%h busy=0 done=0 err=0",
               inst, busy, done, err, IDLE_W);
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (inst !== IDLE_W || busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: inst=%h busy=%b, required inst=%h busy=0", inst, busy, IDLE_W);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    w_base = 11'd100; x_base = 11'd200; p_base = 11'd300; nx = 8'd3; acc_en = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (inst[B_CENX] !== 1'b0 || inst[B_AX +: A] !== 11'd103) begin
      errors++;
      $display("FAIL wfetch_cycle3: cen_x=%b a_x=%0d, required cen_x=0 a_x=103",
               inst[B_CENX], inst[B_AX +: A]);
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (inst !== IDLE_W || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: inst=%h busy=%b, required inst=%h busy=0", inst, busy, IDLE_W);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if (inst !== IDLE_W || busy !== 1'b0) begin
        errors++;
        $display("FAIL after_reset_mid[%0d]: inst=%h busy=%b, required inst=%h busy=0",
                 i, inst, busy, IDLE_W);
      end
    end
  endtask

  // vmode: 0 valid held high, 1 pattern 1,0,0,1, 2 random, 3 stuck low
  task automatic run_pass(input int w, input int x, input int p, input int n,
                          input bit acc, input int vmode, input bit start_mid,
                          input bit exp_to, input string tag);
    int reads[$];
    int writes[$];
    int loads, execs, done_cyc, last_wr, last_load, last_exec, bound, drains;
    bit prev_read, pv, rd_now;
    logic [W-1:0] s;
    loads = 0; execs = 0; done_cyc = -1; last_wr = -1; last_load = -1; last_exec = -1;
    prev_read = 1'b0;
    bound = exp_to ? 1400 : (100 + 2*COL + ROW + 8*n);

    @(negedge clk);
    w_base = A'(w); x_base = A'(x); p_base = A'(p); nx = LB'(n); acc_en = acc;
    ofifo_valid = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    // later input changes must not affect the running pass
    w_base = A'($urandom); x_base = A'($urandom); p_base = A'($urandom);
    nx = LB'($urandom); acc_en = ~acc;

    for (int cyc = 0; cyc < bound && done_cyc < 0; cyc++) begin
      s  = inst;
      pv = ofifo_valid;
      rd_now = (s[B_CENX] === 1'b0);
      if (rd_now) reads.push_back(int'(s[B_AX +: A]));
      checks++;
      if (s[B_L0WR] !== prev_read || s[B_IFRD] !== 1'b0 || s[B_IFWR] !== 1'b0 || s[B_WENX] !== 1'b1) begin
        errors++;
        $display("FAIL %s fetch_bits[%0d]: l0_wr=%b if_rd=%b if_wr=%b wen_x=%b, required l0_wr=%b 0 0 1",
                 tag, cyc, s[B_L0WR], s[B_IFRD], s[B_IFWR], s[B_WENX], prev_read);
      end
      prev_read = rd_now;
      if (s[B_LOAD] === 1'b1) begin loads++; last_load = cyc; end
      if (s[B_EXE] === 1'b1) begin execs++; last_exec = cyc; end
      if ((s[B_LOAD] === 1'b1 || s[B_EXE] === 1'b1) &&
          (s[B_L0RD] !== 1'b1 || s[B_LOAD] === s[B_EXE])) begin
        checks++; errors++;
        $display("FAIL %s l0_rd[%0d]: load=%b exe=%b l0_rd=%b, required l0_rd=1 and one of load/exe",
                 tag, cyc, s[B_LOAD], s[B_EXE], s[B_L0RD]);
      end
      if (s[B_CENP] === 1'b0) begin
        writes.push_back(int'(s[B_AP +: A]));
        last_wr = cyc;
        checks++;
        if (s[B_WENP] !== 1'b0 || s[B_OFRD] !== 1'b1 || s[B_ACC] !== acc || pv !== 1'b1) begin
          errors++;
          $display("FAIL %s pmem_write[%0d]: wen_p=%b of_rd=%b acc=%b valid=%b, required 0 1 %b 1",
                   tag, cyc, s[B_WENP], s[B_OFRD], s[B_ACC], pv, acc);
        end
      end
      checks++;
      if (busy !== 1'b1) begin
        errors++;
        $display("FAIL %s busy[%0d]: busy=%b, required 1", tag, cyc, busy);
      end
      if (done === 1'b1) done_cyc = cyc;
      checks++;
      if (err !== ((exp_to && done === 1'b1) ? 1'b1 : 1'b0)) begin
        errors++;
        $display("FAIL %s err[%0d]: err=%b done=%b, required err=%b", tag, cyc, err, done,
                 (exp_to && done === 1'b1));
      end
      case (vmode)
        0: ofifo_valid = 1'b1;
        1: ofifo_valid = (cyc % 4 == 0) || (cyc % 4 == 3);
        2: ofifo_valid = 1'($urandom_range(0, 1));
        default: ofifo_valid = 1'b0;
      endcase
      start = (start_mid && cyc == 5) || (done === 1'b1);
      if (start_mid && cyc == 5) begin
        w_base = A'($urandom); nx = LB'($urandom_range(1, 20));
      end
      @(negedge clk);
    end
    start = 1'b0;
    ofifo_valid = 1'b0;

    checks++;
    if (done_cyc < 0) begin
      errors++;
      $display("FAIL %s done_timeout: no done within %0d cycles, required done", tag, bound);
    end
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || inst !== IDLE_W || err !== exp_to) begin
      errors++;
      $display("FAIL %s after_done: busy=%b done=%b inst=%h err=%b, required 0 0 %h %b",
               tag, busy, done, inst, err, IDLE_W, exp_to);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || err !== exp_to) begin
      errors++;
      $display("FAIL %s start_in_done: busy=%b err=%b, required busy=0 err=%b", tag, busy, err, exp_to);
    end

    checks++;
    if (reads.size() != COL + n) begin
      errors++;
      $display("FAIL %s read_count: %0d, required %0d", tag, reads.size(), COL + n);
    end
    for (int k = 0; k < reads.size() && k < COL + n; k++) begin
      int e;
      e = (k < COL) ? (w + k) % AMOD : (x + k - COL) % AMOD;
      checks++;
      if (reads[k] != e) begin
        errors++;
        $display("FAIL %s read_addr[%0d]: %0d, required %0d", tag, k, reads[k], e);
      end
    end
    checks++;
    if (loads != COL || execs != n) begin
      errors++;
      $display("FAIL %s load_exec: loads=%0d execs=%0d, required %0d %0d", tag, loads, execs, COL, n);
    end
    checks++;
    if (writes.size() != (exp_to ? 0 : n)) begin
      errors++;
      $display("FAIL %s write_count: %0d, required %0d", tag, writes.size(), exp_to ? 0 : n);
    end
    for (int i = 0; i < writes.size() && i < n; i++) begin
      checks++;
      if (writes[i] != (p + i) % AMOD) begin
        errors++;
        $display("FAIL %s write_addr[%0d]: %0d, required %0d", tag, i, writes[i], (p + i) % AMOD);
      end
    end
    if (done_cyc >= 0) begin
      if (exp_to) begin
        drains = done_cyc - last_exec - 1;
        checks++;
        if (drains != 1023) begin
          errors++;
          $display("FAIL %s timeout_len: %0d drain cycles, required 1023", tag, drains);
        end
      end else if (n == 0) begin
        checks++;
        if (done_cyc != last_load + ROW + 1) begin
          errors++;
          $display("FAIL %s done_after_wload: cycle %0d, required %0d", tag, done_cyc, last_load + ROW + 1);
        end
      end else begin
        checks++;
        if (done_cyc != last_wr + 1) begin
          errors++;
          $display("FAIL %s done_after_write: cycle %0d, required %0d", tag, done_cyc, last_wr + 1);
        end
      end
    end
  endtask

  task automatic test_basic();
    run_pass(0, 8, 0, 4, 1'b0, 0, 1'b0, 1'b0, "basic");
  endtask

  task automatic test_backpressure();
    run_pass(0, 8, 0, 4, 1'b0, 1, 1'b0, 1'b0, "toggle");
  endtask

  task automatic test_nx_zero();
    run_pass(40, 80, 120, 0, 1'b0, 0, 1'b1, 1'b0, "nx0");
  endtask

  task automatic test_wrap();
    run_pass(2046, 2044, 2045, 5, 1'b1, 1, 1'b0, 1'b0, "wrap");
  endtask

  task automatic test_random();
    for (int r = 0; r < 5; r++) begin
      run_pass(int'($urandom_range(0, AMOD - 1)), int'($urandom_range(0, AMOD - 1)),
               int'($urandom_range(0, AMOD - 1)), int'($urandom_range(0, 12)),
               1'($urandom_range(0, 1)), 2, 1'($urandom_range(0, 1)), 1'b0, "random");
    end
  endtask

`ifdef CORE_INST_SEQ_TIMEOUT_EN
  task automatic test_timeout();
    run_pass(16, 32, 48, 2, 1'b0, 3, 1'b0, 1'b1, "timeout");
    repeat (5) @(negedge clk);
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL timeout_sticky: err=%b, required 1", err);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL timeout_clear: err=%b, required 0", err);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_reset_mid();
    test_basic();
    test_backpressure();
    test_nx_zero();
    test_wrap();
    test_random();
`ifdef CORE_INST_SEQ_TIMEOUT_EN
    test_timeout();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
